// File: rtl/cpu_pkg.sv
// Shared RV32I decode constants, the id/ex bundle type, and the bubble helper.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    COND_NEVER    = 2'd0,
    COND_ALWAYS   = 2'd1,
    COND_ZERO     = 2'd2,
    COND_NOT_ZERO = 2'd3
  } jump_cond_e;

  typedef enum logic [1:0] {
    CSR_NOP = 2'd0,
    CSR_RW  = 2'd1,
    CSR_RS  = 2'd2,
    CSR_RC  = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} alu_a_e;
  typedef enum logic {B_RS2 = 1'b0, B_IMM = 1'b1} alu_b_e;
  typedef enum logic [1:0] {RD_ALU = 2'd0, RD_PC4 = 2'd1, RD_DMEM = 2'd2, RD_CSR = 2'd3} rd_src_e;
  typedef enum logic {BASE_PC = 1'b0, BASE_RS1 = 1'b1} base_e;
  typedef enum logic [1:0] {WIDTH_BYTE = 2'd0, WIDTH_HALF = 2'd1, WIDTH_WORD = 2'd2} width_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INS_MRET   = 32'h3020_0073;

  typedef struct packed {
    logic        ins_misalign;
    logic        ins_illegal;
    logic        ecall;
    logic        ebreak;
    logic        trap_return;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [3:0]  alu_op;
    logic [1:0]  alu_a_src;
    logic        alu_b_src;
    logic [1:0]  dmem_width;
    logic        dmem_zero_ext;
    logic        dmem_read;
    logic        dmem_write;
    logic        jump_base_src;
    logic [1:0]  jump_cond;
    logic        rd_wen;
    logic [1:0]  rd_src;
    logic [4:0]  rd_addr;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic        csr_src;
  } id_ex_t;

  function automatic id_ex_t id_ex_bubble(input logic [31:0] pc);
    id_ex_t b;
    b           = '0;
    b.pc        = pc;
    b.alu_op    = ALU_ADD;
    b.jump_cond = COND_NEVER;
    b.csr_op    = CSR_NOP;
    return b;
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32x32 integer register file: two read ports, one write port, x0 hardwired to zero,
// and write-to-read bypass so decode sees the value being written back this cycle.
module rv32i_regfile
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        wen_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wen_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  function automatic logic [31:0] rd_port(input logic [4:0] a, input logic [31:0] stored);
    if (a == 5'd0)                       return '0;
    else if (wen_i && (waddr_i == a))    return wdata_i;
    else                                 return stored;
  endfunction

  assign rdata1_o = rd_port(raddr1_i, regs_q[raddr1_i]);
  assign rdata2_o = rd_port(raddr2_i, regs_q[raddr2_i]);

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: instruction decode, register read, load-use detection, id/ex register.
// Build option DECODE_FENCE_NOP_EN decodes FENCE/FENCE.I as a NOP instead of illegal.
module rv32i_decode_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_flush,
  input  logic        if_id__ins_misalign,
  input  logic [31:0] if_id__ins,
  input  logic [31:0] if_id__pc,
  input  logic        if_id__data_hazard,
  input  logic        wb_id__rd_wen,
  input  logic [4:0]  wb_id__rd_addr,
  input  logic [31:0] wb_id__rd_wdata,
  output logic        id_ex__ins_misalign,
  output logic        id_ex__ins_illegal,
  output logic        id_ex__ecall,
  output logic        id_ex__ebreak,
  output logic        id_ex__trap_return,
  output logic [31:0] id_ex__pc,
  output logic [31:0] id_ex__imm,
  output logic [31:0] id_ex__rs1_rdata,
  output logic [31:0] id_ex__rs2_rdata,
  output logic [4:0]  id_ex__rs1_addr,
  output logic [4:0]  id_ex__rs2_addr,
  output logic [3:0]  id_ex__alu_op,
  output logic [1:0]  id_ex__alu_a_src,
  output logic        id_ex__alu_b_src,
  output logic [1:0]  id_ex__dmem_width,
  output logic        id_ex__dmem_zero_ext,
  output logic        id_ex__dmem_read,
  output logic        id_ex__dmem_write,
  output logic        id_ex__jump_base_src,
  output logic [1:0]  id_ex__jump_cond,
  output logic        id_ex__rd_wen,
  output logic [1:0]  id_ex__rd_src,
  output logic [4:0]  id_ex__rd_addr,
  output logic [11:0] id_ex__csr_addr,
  output logic [1:0]  id_ex__csr_op,
  output logic        id_ex__csr_src,
  output logic        data_hazard
);

  logic [31:0] ins;
  logic [6:0]  opc, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
  id_ex_t      dec, id_ex_d, id_ex_q;
  logic [31:0] rf_rdata1, rf_rdata2;

  assign ins    = if_id__ins;
  assign opc    = ins[6:0];
  assign rd     = ins[11:7];
  assign funct3 = ins[14:12];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];
  assign funct7 = ins[31:25];

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_z = {27'b0, ins[19:15]};

  always_comb begin
    logic illegal, use1, use2, wr;
    dec     = id_ex_bubble(if_id__pc);
    illegal = 1'b0;
    use1    = 1'b0;
    use2    = 1'b0;
    wr      = 1'b0;
    case (opc)
      OPC_LUI: begin
        dec.alu_a_src = A_ZERO; dec.alu_b_src = B_IMM; dec.imm = imm_u; wr = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_a_src = A_PC; dec.alu_b_src = B_IMM; dec.imm = imm_u; wr = 1'b1;
      end
      OPC_JAL: begin
        dec.alu_a_src = A_PC; dec.alu_b_src = B_IMM; dec.imm = imm_j;
        dec.jump_cond = COND_ALWAYS; dec.jump_base_src = BASE_PC; dec.rd_src = RD_PC4;
        wr = 1'b1;
      end
      OPC_JALR: begin
        illegal = (funct3 != 3'd0);
        use1 = 1'b1; dec.alu_b_src = B_IMM; dec.imm = imm_i;
        dec.jump_cond = COND_ALWAYS; dec.jump_base_src = BASE_RS1; dec.rd_src = RD_PC4;
        wr = 1'b1;
      end
      OPC_BRANCH: begin
        use1 = 1'b1; use2 = 1'b1; dec.imm = imm_b; dec.jump_base_src = BASE_PC;
        case (funct3)
          3'd0:    begin dec.alu_op = ALU_SUB;  dec.jump_cond = COND_ZERO;     end
          3'd1:    begin dec.alu_op = ALU_SUB;  dec.jump_cond = COND_NOT_ZERO; end
          3'd4:    begin dec.alu_op = ALU_SLT;  dec.jump_cond = COND_NOT_ZERO; end
          3'd5:    begin dec.alu_op = ALU_SLT;  dec.jump_cond = COND_ZERO;     end
          3'd6:    begin dec.alu_op = ALU_SLTU; dec.jump_cond = COND_NOT_ZERO; end
          3'd7:    begin dec.alu_op = ALU_SLTU; dec.jump_cond = COND_ZERO;     end
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        // funct3[1:0] is the access width, funct3[2] selects zero extension
        illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        use1 = 1'b1; dec.alu_b_src = B_IMM; dec.imm = imm_i;
        dec.dmem_read = 1'b1; dec.dmem_width = funct3[1:0]; dec.dmem_zero_ext = funct3[2];
        dec.rd_src = RD_DMEM; wr = 1'b1;
      end
      OPC_STORE: begin
        illegal = (funct3 > 3'd2);
        use1 = 1'b1; use2 = 1'b1; dec.alu_b_src = B_IMM; dec.imm = imm_s;
        dec.dmem_write = 1'b1; dec.dmem_width = funct3[1:0];
      end
      OPC_OP_IMM: begin
        use1 = 1'b1; dec.alu_b_src = B_IMM; dec.imm = imm_i; wr = 1'b1;
        case (funct3)
          3'd0: dec.alu_op = ALU_ADD;
          3'd1: begin dec.alu_op = ALU_SLL; illegal = (funct7 != 7'h00); end
          3'd2: dec.alu_op = ALU_SLT;
          3'd3: dec.alu_op = ALU_SLTU;
          3'd4: dec.alu_op = ALU_XOR;
          3'd5: begin
            dec.alu_op = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            illegal    = (funct7 != 7'h00) && (funct7 != 7'h20);
          end
          3'd6: dec.alu_op = ALU_OR;
          default: dec.alu_op = ALU_AND;
        endcase
      end
      OPC_OP: begin
        use1 = 1'b1; use2 = 1'b1; dec.alu_b_src = B_RS2; wr = 1'b1;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0: dec.alu_op = ALU_ADD;
            3'd1: dec.alu_op = ALU_SLL;
            3'd2: dec.alu_op = ALU_SLT;
            3'd3: dec.alu_op = ALU_SLTU;
            3'd4: dec.alu_op = ALU_XOR;
            3'd5: dec.alu_op = ALU_SRL;
            3'd6: dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
          dec.alu_op = ALU_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
          dec.alu_op = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'd0) begin
          if (ins == INS_ECALL)       dec.ecall       = 1'b1;
          else if (ins == INS_EBREAK) dec.ebreak      = 1'b1;
          else if (ins == INS_MRET)   dec.trap_return = 1'b1;
          else                        illegal         = 1'b1;
        end else if (funct3 == 3'd4) begin
          illegal = 1'b1;
        end else begin
          dec.csr_addr = ins[31:20];
          dec.csr_op   = funct3[1:0];
          dec.csr_src  = funct3[2];
          dec.rd_src   = RD_CSR;
          wr           = 1'b1;
          use1         = !funct3[2];
          if (funct3[2]) dec.imm = imm_z;
        end
      end
      OPC_MISC_MEM: begin
`ifdef DECODE_FENCE_NOP_EN
        illegal = 1'b0;
`else
        illegal = 1'b1;
`endif
      end
      default: illegal = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) illegal = 1'b1;

    dec.rs1_addr = use1 ? rs1 : 5'd0;
    dec.rs2_addr = use2 ? rs2 : 5'd0;
    dec.rd_wen   = wr && (rd != 5'd0);
    dec.rd_addr  = dec.rd_wen ? rd : 5'd0;

    if (illegal) begin
      dec             = id_ex_bubble(if_id__pc);
      dec.ins_illegal = 1'b1;
    end
  end

  rv32i_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1_i (dec.rs1_addr),
    .raddr2_i (dec.rs2_addr),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2),
    .wen_i    (wb_id__rd_wen),
    .waddr_i  (wb_id__rd_addr),
    .wdata_i  (wb_id__rd_wdata)
  );

  // A re-presented instruction has already waited out its load, so it never stalls twice.
  assign data_hazard = id_ex_q.dmem_read && (id_ex_q.rd_addr != 5'd0) &&
                       ((dec.rs1_addr == id_ex_q.rd_addr) || (dec.rs2_addr == id_ex_q.rd_addr)) &&
                       !if_id__data_hazard && !pipe_flush;

  always_comb begin
    id_ex_d = id_ex_bubble('0);
    if (pipe_flush || data_hazard) begin
      id_ex_d = id_ex_bubble('0);
    end else if (if_id__ins_misalign) begin
      id_ex_d              = id_ex_bubble(if_id__pc);
      id_ex_d.ins_misalign = 1'b1;
    end else begin
      id_ex_d           = dec;
      id_ex_d.rs1_rdata = rf_rdata1;
      id_ex_d.rs2_rdata = rf_rdata2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) id_ex_q <= id_ex_bubble(RESET_PC);
    else        id_ex_q <= id_ex_d;
  end

  assign id_ex__ins_misalign  = id_ex_q.ins_misalign;
  assign id_ex__ins_illegal   = id_ex_q.ins_illegal;
  assign id_ex__ecall         = id_ex_q.ecall;
  assign id_ex__ebreak        = id_ex_q.ebreak;
  assign id_ex__trap_return   = id_ex_q.trap_return;
  assign id_ex__pc            = id_ex_q.pc;
  assign id_ex__imm           = id_ex_q.imm;
  assign id_ex__rs1_rdata     = id_ex_q.rs1_rdata;
  assign id_ex__rs2_rdata     = id_ex_q.rs2_rdata;
  assign id_ex__rs1_addr      = id_ex_q.rs1_addr;
  assign id_ex__rs2_addr      = id_ex_q.rs2_addr;
  assign id_ex__alu_op        = id_ex_q.alu_op;
  assign id_ex__alu_a_src     = id_ex_q.alu_a_src;
  assign id_ex__alu_b_src     = id_ex_q.alu_b_src;
  assign id_ex__dmem_width    = id_ex_q.dmem_width;
  assign id_ex__dmem_zero_ext = id_ex_q.dmem_zero_ext;
  assign id_ex__dmem_read     = id_ex_q.dmem_read;
  assign id_ex__dmem_write    = id_ex_q.dmem_write;
  assign id_ex__jump_base_src = id_ex_q.jump_base_src;
  assign id_ex__jump_cond     = id_ex_q.jump_cond;
  assign id_ex__rd_wen        = id_ex_q.rd_wen;
  assign id_ex__rd_src        = id_ex_q.rd_src;
  assign id_ex__rd_addr       = id_ex_q.rd_addr;
  assign id_ex__csr_addr      = id_ex_q.csr_addr;
  assign id_ex__csr_op        = id_ex_q.csr_op;
  assign id_ex__csr_src       = id_ex_q.csr_src;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed-vector bench for rv32i_decode_stage with hand-computed expectations.
module tb_rv32i_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_flush;
  logic        if_id__ins_misalign;
  logic [31:0] if_id__ins;
  logic [31:0] if_id__pc;
  logic        if_id__data_hazard;
  logic        wb_id__rd_wen;
  logic [4:0]  wb_id__rd_addr;
  logic [31:0] wb_id__rd_wdata;
  logic        id_ex__ins_misalign, id_ex__ins_illegal, id_ex__ecall, id_ex__ebreak, id_ex__trap_return;
  logic [31:0] id_ex__pc, id_ex__imm, id_ex__rs1_rdata, id_ex__rs2_rdata;
  logic [4:0]  id_ex__rs1_addr, id_ex__rs2_addr, id_ex__rd_addr;
  logic [3:0]  id_ex__alu_op;
  logic [1:0]  id_ex__alu_a_src, id_ex__dmem_width, id_ex__jump_cond, id_ex__rd_src, id_ex__csr_op;
  logic        id_ex__alu_b_src, id_ex__dmem_zero_ext, id_ex__dmem_read, id_ex__dmem_write;
  logic        id_ex__jump_base_src, id_ex__rd_wen, id_ex__csr_src;
  logic [11:0] id_ex__csr_addr;
  logic        data_hazard;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32i_decode_stage #(.RESET_PC(32'h0000_1000)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .if_id__ins_misalign(if_id__ins_misalign), .if_id__ins(if_id__ins), .if_id__pc(if_id__pc),
    .if_id__data_hazard(if_id__data_hazard),
    .wb_id__rd_wen(wb_id__rd_wen), .wb_id__rd_addr(wb_id__rd_addr), .wb_id__rd_wdata(wb_id__rd_wdata),
    .id_ex__ins_misalign(id_ex__ins_misalign), .id_ex__ins_illegal(id_ex__ins_illegal),
    .id_ex__ecall(id_ex__ecall), .id_ex__ebreak(id_ex__ebreak), .id_ex__trap_return(id_ex__trap_return),
    .id_ex__pc(id_ex__pc), .id_ex__imm(id_ex__imm),
    .id_ex__rs1_rdata(id_ex__rs1_rdata), .id_ex__rs2_rdata(id_ex__rs2_rdata),
    .id_ex__rs1_addr(id_ex__rs1_addr), .id_ex__rs2_addr(id_ex__rs2_addr),
    .id_ex__alu_op(id_ex__alu_op), .id_ex__alu_a_src(id_ex__alu_a_src), .id_ex__alu_b_src(id_ex__alu_b_src),
    .id_ex__dmem_width(id_ex__dmem_width), .id_ex__dmem_zero_ext(id_ex__dmem_zero_ext),
    .id_ex__dmem_read(id_ex__dmem_read), .id_ex__dmem_write(id_ex__dmem_write),
    .id_ex__jump_base_src(id_ex__jump_base_src), .id_ex__jump_cond(id_ex__jump_cond),
    .id_ex__rd_wen(id_ex__rd_wen), .id_ex__rd_src(id_ex__rd_src), .id_ex__rd_addr(id_ex__rd_addr),
    .id_ex__csr_addr(id_ex__csr_addr), .id_ex__csr_op(id_ex__csr_op), .id_ex__csr_src(id_ex__csr_src),
    .data_hazard(data_hazard)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] pc);
    if_id__ins = ins;
    if_id__pc  = pc;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pipe_flush = 1'b0; if_id__ins_misalign = 1'b0;
    if_id__ins = 32'h0000_0013; if_id__pc = '0; if_id__data_hazard = 1'b0;
    wb_id__rd_wen = 1'b0; wb_id__rd_addr = '0; wb_id__rd_wdata = '0;

    #12;
    check("rst_rd_wen",    32'(id_ex__rd_wen), 0);
    check("rst_jump_cond", 32'(id_ex__jump_cond), 0);
    check("rst_csr_op",    32'(id_ex__csr_op), 0);
    check("rst_pc",        id_ex__pc, 32'h0000_1000);
    check("rst_illegal",   32'(id_ex__ins_illegal), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI x1,x0,5
    present(32'h0050_0093, 32'h0000_0100);
    tick();
    check("addi_alu_op", 32'(id_ex__alu_op), 0);
    check("addi_b_src",  32'(id_ex__alu_b_src), 1);
    check("addi_imm",    id_ex__imm, 5);
    check("addi_rd",     32'(id_ex__rd_addr), 1);
    check("addi_rd_wen", 32'(id_ex__rd_wen), 1);
    check("addi_pc",     id_ex__pc, 32'h0000_0100);

    // write x1 while reading it: bypass
    wb_id__rd_wen = 1'b1; wb_id__rd_addr = 5'd1; wb_id__rd_wdata = 32'h0000_1234;
    present(32'h0000_80B3, 32'h0000_0104);
    tick();
    check("bypass_rs1", id_ex__rs1_rdata, 32'h0000_1234);
    check("bypass_rs1_addr", 32'(id_ex__rs1_addr), 1);
    // write to x0 must not bypass or stick
    wb_id__rd_addr = 5'd0; wb_id__rd_wdata = 32'hDEAD_BEEF;
    present(32'h0000_00B3, 32'h0000_0108);
    tick();
    check("x0_bypass", id_ex__rs1_rdata, 0);
    wb_id__rd_wen = 1'b0;
    #1;
    tick();
    check("x0_stored", id_ex__rs1_rdata, 0);
    present(32'h0000_80B3, 32'h0000_010C);
    tick();
    check("x1_stored", id_ex__rs1_rdata, 32'h0000_1234);

    // load-use: LW x2,0(x1) then ADD x3,x2,x2
    present(32'h0000_A103, 32'h0000_0110);
    tick();
    check("lw_dmem_read", 32'(id_ex__dmem_read), 1);
    check("lw_width",     32'(id_ex__dmem_width), 2);
    check("lw_rd_src",    32'(id_ex__rd_src), 2);
    check("lw_rd",        32'(id_ex__rd_addr), 2);
    present(32'h0021_01B3, 32'h0000_0114);
    check("lu_hazard", 32'(data_hazard), 1);
    tick();
    check("lu_bubble_wen", 32'(id_ex__rd_wen), 0);
    check("lu_bubble_hz",  32'(data_hazard), 0);
    if_id__data_hazard = 1'b1;
    #1;
    check("lu_replay_hz", 32'(data_hazard), 0);
    tick();
    if_id__data_hazard = 1'b0;
    check("add_rd_wen", 32'(id_ex__rd_wen), 1);
    check("add_rd",     32'(id_ex__rd_addr), 3);
    check("add_rs1",    32'(id_ex__rs1_addr), 2);
    check("add_rs2",    32'(id_ex__rs2_addr), 2);

    // flush suppresses load-use
    present(32'h0000_A103, 32'h0000_0118);
    tick();
    pipe_flush = 1'b1;
    present(32'h0021_01B3, 32'h0000_011C);
    check("flush_hazard", 32'(data_hazard), 0);
    tick();
    pipe_flush = 1'b0;
    check("flush_rd_wen", 32'(id_ex__rd_wen), 0);

    // BNE x1,x2,-4
    present(32'hFE20_9EE3, 32'h0000_0120);
    tick();
    check("bne_alu_op", 32'(id_ex__alu_op), 1);
    check("bne_cond",   32'(id_ex__jump_cond), 3);
    check("bne_imm",    id_ex__imm, 32'hFFFF_FFFC);
    check("bne_rd_wen", 32'(id_ex__rd_wen), 0);
    check("bne_rs2",    32'(id_ex__rs2_addr), 2);

    // SUB and an illegal funct7
    present(32'h4020_81B3, 32'h0000_0124);
    tick();
    check("sub_alu_op", 32'(id_ex__alu_op), 1);
    present(32'h0220_81B3, 32'h0000_0128);
    tick();
    check("f7_illegal", 32'(id_ex__ins_illegal), 1);
    check("f7_rd_wen",  32'(id_ex__rd_wen), 0);

    // system
    present(32'h0000_0073, 32'h0000_012C);
    tick();
    check("ecall",       32'(id_ex__ecall), 1);
    check("ecall_legal", 32'(id_ex__ins_illegal), 0);
    present(32'h3020_0073, 32'h0000_0130);
    tick();
    check("mret", 32'(id_ex__trap_return), 1);
    present(32'h0000_0000, 32'h0000_0134);
    tick();
    check("zero_illegal", 32'(id_ex__ins_illegal), 1);
    pipe_flush = 1'b1;
    present(32'h0000_0073, 32'h0000_0138);
    tick();
    check("flush_ecall", 32'(id_ex__ecall), 0);
    present(32'h0000_0000, 32'h0000_013C);
    tick();
    check("flush_illegal", 32'(id_ex__ins_illegal), 0);
    pipe_flush = 1'b0;

    // CSRRW x1,mstatus,x2
    present(32'h3001_10F3, 32'h0000_0140);
    tick();
    check("csr_addr",   32'(id_ex__csr_addr), 32'h300);
    check("csr_op",     32'(id_ex__csr_op), 1);
    check("csr_rd_src", 32'(id_ex__rd_src), 3);
    check("csr_src",    32'(id_ex__csr_src), 0);
    check("csr_rs1",    32'(id_ex__rs1_addr), 2);

    // FENCE
    present(32'h0000_000F, 32'h0000_0144);
    tick();
`ifdef DECODE_FENCE_NOP_EN
    check("fence_illegal", 32'(id_ex__ins_illegal), 0);
`else
    check("fence_illegal", 32'(id_ex__ins_illegal), 1);
`endif
    check("fence_rd_wen", 32'(id_ex__rd_wen), 0);

    // misaligned fetch
    if_id__ins_misalign = 1'b1;
    present(32'h0050_0093, 32'h0000_0146);
    tick();
    check("mis_flag",   32'(id_ex__ins_misalign), 1);
    check("mis_rd_wen", 32'(id_ex__rd_wen), 0);
    if_id__ins_misalign = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
